// File: rtl/pc_predict_unit.sv
// Fetch PC generator: flush, RAS pop, BTB target or sequential step.
// Run/halt control, circular return-address stack, saturating counters.
module pc_predict_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned END_ADDR  = 18,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush_pipeline,
  input  logic [ADDR_W-1:0] true_address,
  input  logic              prediction,
  input  logic [ADDR_W-1:0] BTB_address,
  input  logic              is_call,
  input  logic              is_return,
  output logic [ADDR_W-1:0] next_PC,
  output logic              pc_valid,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  redirect_count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned OCC_W = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RST_V  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] END_V  = ADDR_W'(END_ADDR);
  localparam logic [OCC_W-1:0]  FULL_V = OCC_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  fetch_q, fetch_d;
  logic [CNT_W-1:0]  redir_q, redir_d;
  logic              fetch_en;
  logic              push;
  logic              pop;
  logic              redirect;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] ras_top;

  assign fetch_en = (state_q == RUN) && !stall;
  assign seq_pc   = pc_q + STEP_V;
  assign ras_top  = ras_q[ptr_q - PTR_W'(1)];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    pop      = 1'b0;
    redirect = 1'b0;
    if (state_q == HALT) begin
      if (flush_pipeline) begin
        pc_d     = true_address;
        redirect = 1'b1;
        state_d  = (true_address >= END_V) ? HALT : RUN;
      end
    end else if (flush_pipeline) begin
      pc_d     = true_address;
      redirect = 1'b1;
    end else if (pc_q >= END_V) begin
      state_d = HALT;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (is_return && occ_q != '0) begin
      pc_d     = ras_top;
      pop      = 1'b1;
      redirect = 1'b1;
    end else if (prediction) begin
      pc_d     = BTB_address;
      push     = is_call;
      redirect = 1'b1;
    end else begin
      pc_d = seq_pc;
    end
  end

  // Full stack push overwrites the oldest slot: pointer moves, occupancy pins.
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    occ_d = occ_q;
    if (push) begin
      ras_d[ptr_q] = seq_pc;
      ptr_d        = ptr_q + PTR_W'(1);
      occ_d        = (occ_q == FULL_V) ? occ_q : occ_q + OCC_W'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      occ_d = occ_q - OCC_W'(1);
    end
    empty_d = (occ_d == '0);
    full_d  = (occ_d == FULL_V);
  end

  always_comb begin
    fetch_d = fetch_q;
    redir_d = redir_q;
    if (fetch_en && fetch_q != '1) fetch_d = fetch_q + CNT_W'(1);
    if (redirect && redir_q != '1) redir_d = redir_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RST_V;
      ptr_q   <= '0;
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      fetch_q <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      fetch_q <= fetch_d;
      redir_q <= redir_d;
    end
  end

  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign next_PC        = pc_q;
  assign pc_valid       = fetch_en;
  assign halted         = (state_q == HALT);
  assign ras_empty      = empty_q;
  assign ras_full       = full_q;
  assign fetch_count    = fetch_q;
  assign redirect_count = redir_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios plus randomized run
// against a queue-based reference model; second instance for wrap/saturation.
module tb_pc_predict_unit;

  logic        clk;
  logic        rst, stall, flush, pred, call, ret;
  logic [31:0] ta, btb;
  logic [31:0] pc;
  logic        pv, hlt, remp, rful;
  logic [15:0] fc, rc;

  logic        w_rst, w_stall, w_flush, w_pred, w_call, w_ret;
  logic [7:0]  w_ta, w_btb, w_pc;
  logic        w_pv, w_hlt, w_remp, w_rful;
  logic [2:0]  w_fc, w_rc;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_ras[$];
  int          m_fetch, m_redir;

  pc_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush_pipeline(flush), .true_address(ta),
    .prediction(pred), .BTB_address(btb),
    .is_call(call), .is_return(ret),
    .next_PC(pc), .pc_valid(pv), .halted(hlt),
    .ras_empty(remp), .ras_full(rful),
    .fetch_count(fc), .redirect_count(rc)
  );

  pc_predict_unit #(
    .ADDR_W(8), .STEP(4), .RESET_PC(0),
    .END_ADDR(255), .RAS_DEPTH(2), .CNT_W(3)
  ) dut_w (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .flush_pipeline(w_flush), .true_address(w_ta),
    .prediction(w_pred), .BTB_address(w_btb),
    .is_call(w_call), .is_return(w_ret),
    .next_PC(w_pc), .pc_valid(w_pv), .halted(w_hlt),
    .ras_empty(w_remp), .ras_full(w_rful),
    .fetch_count(w_fc), .redirect_count(w_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_halt = 0; m_ras.delete();
      m_fetch = 0; m_redir = 0;
    end else begin
      if (!m_halt && !stall) m_fetch = sat16(m_fetch);
      if (m_halt) begin
        if (flush) begin
          m_pc = ta; m_halt = (ta >= 18);
          m_redir = sat16(m_redir);
        end
      end else if (flush) begin
        m_pc = ta; m_redir = sat16(m_redir);
      end else if (m_pc >= 18) begin
        m_halt = 1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        m_redir = sat16(m_redir);
      end else if (pred) begin
        if (call) begin
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 1);
        end
        m_pc = btb; m_redir = sat16(m_redir);
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic drive(input logic r, f, input logic [31:0] a,
                       input logic p, input logic [31:0] b,
                       input logic c, rt, s);
    @(negedge clk);
    rst = r; flush = f; ta = a; pred = p; btb = b;
    call = c; ret = rt; stall = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic w_drive(input logic r, f, input logic [7:0] a);
    @(negedge clk);
    w_rst = r; w_flush = f; w_ta = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 9, 1, 5, 1, 1, 1);
    total++;
    if (pc !== 0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++;
    if ({hlt, remp, rful} !== 3'b010) begin
      bad++; $display("FAIL reset_flags got=%b exp=010", {hlt, remp, rful});
    end
    total++;
    if (fc !== 0 || rc !== 0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", fc, rc);
    end
  endtask

  task automatic test_sequential();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      total++;
      if (pc !== 32'(i)) begin
        bad++; $display("FAIL seq_pc got=%0d exp=%0d", pc, i);
      end
    end
    total++;
    if (fc !== 5 || rc !== 0) begin
      bad++; $display("FAIL seq_cnt got=%0d/%0d exp=5/0", fc, rc);
    end
  endtask

  task automatic test_call_return();
    logic [31:0] exp_pc[5] = '{10, 11, 12, 4, 5};
    logic        exp_em[5] = '{0, 0, 0, 1, 1};
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(0, 0, 0, 1, 10, 1, 0, 0);
      else if (i == 3) drive(0, 0, 0, 0, 0, 0, 1, 0);
      else idle();
      total++;
      if (pc !== exp_pc[i] || remp !== exp_em[i]) begin
        bad++;
        $display("FAIL call_ret[%0d] got=%0d/%b exp=%0d/%b",
                 i, pc, remp, exp_pc[i], exp_em[i]);
      end
    end
    total++;
    if (rc !== 2) begin bad++; $display("FAIL call_ret_redir got=%0d exp=2", rc); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_pc[5] = '{10, 8, 6, 4, 5};
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 32'(3 + 2 * i), 1, 0, 0);
    total++;
    if (rful !== 1 || pc !== 11) begin
      bad++; $display("FAIL ras_full got=%b/%0d exp=1/11", rful, pc);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      total++;
      if (pc !== exp_pc[i]) begin
        bad++; $display("FAIL ras_pop[%0d] got=%0d exp=%0d", i, pc, exp_pc[i]);
      end
    end
    total++;
    if (remp !== 1 || rful !== 0) begin
      bad++; $display("FAIL ras_drained got=%b%b exp=10", remp, rful);
    end
  endtask

  task automatic test_flush_stall();
    logic [15:0] f0, r0;
    drive(0, 1, 7, 1, 3, 0, 0, 1);
    total++;
    if (pc !== 7) begin bad++; $display("FAIL flush_stall got=%0d exp=7", pc); end
    f0 = fc; r0 = rc;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 2, 1, 1, 1);
      total++;
      if (pc !== 7 || pv !== 0 || fc !== f0 || rc !== r0) begin
        bad++;
        $display("FAIL stall[%0d] got=%0d/%b/%0d/%0d exp=7/0/%0d/%0d",
                 i, pc, pv, fc, rc, f0, r0);
      end
    end
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (18) idle();
    total++;
    if (pc !== 18 || hlt !== 0) begin
      bad++; $display("FAIL halt_reach got=%0d/%b exp=18/0", pc, hlt);
    end
    idle();
    drive(0, 0, 0, 1, 3, 1, 0, 0);
    total++;
    if (pc !== 18 || hlt !== 1 || pv !== 0) begin
      bad++; $display("FAIL halt_hold got=%0d/%b/%b exp=18/1/0", pc, hlt, pv);
    end
    drive(0, 1, 2, 0, 0, 0, 0, 0);
    total++;
    if (pc !== 2 || hlt !== 0) begin
      bad++; $display("FAIL halt_resume got=%0d/%b exp=2/0", pc, hlt);
    end
    drive(0, 1, 18, 0, 0, 0, 0, 0);
    idle();
    drive(0, 1, 20, 0, 0, 0, 0, 0);
    total++;
    if (pc !== 20 || hlt !== 1) begin
      bad++; $display("FAIL halt_stay got=%0d/%b exp=20/1", pc, hlt);
    end
  endtask

  task automatic test_wrap_sat();
    w_drive(1, 0, 0);
    w_drive(1, 0, 0);
    w_drive(0, 1, 252);
    total++;
    if (w_pc !== 252) begin bad++; $display("FAIL wrap_load got=%0d exp=252", w_pc); end
    w_drive(0, 0, 0);
    total++;
    if (w_pc !== 0 || w_hlt !== 0) begin
      bad++; $display("FAIL wrap got=%0d/%b exp=0/0", w_pc, w_hlt);
    end
    repeat (6) w_drive(0, 0, 0);
    total++;
    if (w_fc !== 7 || w_pc !== 24) begin
      bad++; $display("FAIL fetch_sat got=%0d/%0d exp=7/24", w_fc, w_pc);
    end
    repeat (7) w_drive(0, 1, 8);
    total++;
    if (w_rc !== 7) begin bad++; $display("FAIL redir_sat got=%0d exp=7", w_rc); end
  endtask

  task automatic test_random();
    logic r, f, p, c, rt, s;
    logic [31:0] a, b;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) < 8);
      s  = ($urandom_range(0, 99) < 20);
      p  = ($urandom_range(0, 99) < 30);
      c  = $urandom_range(0, 1);
      rt = ($urandom_range(0, 99) < 25);
      a  = $urandom_range(0, 22);
      b  = $urandom_range(0, 22);
      drive(r, f, a, p, b, c, rt, s);
      total++;
      if (pc !== m_pc || hlt !== m_halt || pv !== (!m_halt && !s) ||
          remp !== (m_ras.size() == 0) || rful !== (m_ras.size() == 4) ||
          fc !== 16'(m_fetch) || rc !== 16'(m_redir)) begin
        bad++;
        $display("FAIL rand[%0d] got pc=%0d h=%b v=%b e=%b f=%b fc=%0d rc=%0d exp pc=%0d h=%b v=%b e=%b f=%b fc=%0d rc=%0d",
                 i, pc, hlt, pv, remp, rful, fc, rc,
                 m_pc, m_halt, !m_halt && !s, m_ras.size() == 0,
                 m_ras.size() == 4, m_fetch, m_redir);
      end
    end
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; ta = 0; pred = 0;
    btb = 0; call = 0; ret = 0;
    w_rst = 1; w_stall = 0; w_flush = 0; w_ta = 0;
    w_pred = 0; w_btb = 0; w_call = 0; w_ret = 0;
    m_pc = 0; m_halt = 0; m_fetch = 0; m_redir = 0;
    test_reset();
    test_sequential();
    test_call_return();
    test_ras_overflow();
    test_flush_stall();
    test_halt();
    test_wrap_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
